y_alu: RTL and testbench
========================

# y_alu

32-bit ALU used in the single-cycle CPU datapath. It computes AND, OR, ADD, SUB or signed set-less-than on two 32-bit operands, as selected by a 3-bit op code. It also produces a zero flag for branch decisions. The result and flag are registered on the system clock.

## Interface
Parameters:
- none; width is fixed at 32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- z  output  32  registered ALU result.
- ex  output  1  registered zero flag; 1 when the result is all-zero.
- a  input  32  operand A, two's complement.
- b  input  32  operand B, two's complement.
- op  input  3  operation select.

## Operation
Op codes:
- 3'b000: z = a & b.
- 3'b001: z = a | b.
- 3'b010: z = a + b, modulo 2^32. Carry-out and overflow are discarded.
- 3'b110: z = a - b, computed as a + ~b + 1, modulo 2^32.
- 3'b111: z = 32'd1 if a < b as signed values, else 32'd0.
  - Signed compare = sign bit of (a - b) XOR signed overflow of (a - b).
  - This is correct at extremes, e.g. a = 0x80000000, b = 1 gives 1.
- Any other op (011, 100, 101): z = 0, so ex = 1.

Zero flag and datapath:
- ex = (result == 0), evaluated on the same result that is loaded into z.
- Datapath structure:
  - One shared adder.
  - B-invert and carry-in are driven by op[2].
  - The adder feeds both ADD/SUB and SLT.
  - A 32-bit result mux selects between AND, OR, SUM and SLT.

## Timing
- Combinational result is captured on the rising clk edge. Latency is 1 cycle: inputs applied before edge N appear on z/ex after edge N.
- Outputs hold their value until the next edge. No valid/ready handshake; every cycle produces a new result.
- When rst = 1 at a rising edge: z = 0 and ex = 1 (a zero result). rst takes priority over inputs.
- Reset asserted mid-stream discards the in-flight result. The first valid result appears one edge after rst deasserts.
- Inputs may change every cycle. Only the values present at each edge matter.

## Structure
- Shared package holds:
  - op code localparams: OP_AND = 3'b000, OP_OR = 3'b001, OP_ADD = 3'b010, OP_SUB = 3'b110, OP_SLT = 3'b111.
  - width constant DATA_W = 32.
- One sub-module, y_add_sub: 32-bit ripple or carry-select adder.
  - Inputs: a, b, sub.
  - Outputs: sum, carry-out, signed overflow.
- Top level holds the logic unit, SLT formation, result mux, zero detect and output registers.

## Test plan
- Reset: hold rst = 1 for 2 cycles with random inputs -> z = 0, ex = 1. Then release with a = 5, b = 3, op = 010 -> next cycle z = 8, ex = 0.
- Logic ops: a = 0xF0F0_00FF, b = 0x0FF0_0F0F.
  - op = 000 -> z = 0x00F0_000F.
  - op = 001 -> z = 0xFFF0_0FFF.
- Add/sub wrap:
  - a = 0xFFFF_FFFF, b = 1, op = 010 -> z = 0, ex = 1.
  - a = 0, b = 1, op = 110 -> z = 0xFFFF_FFFF, ex = 0.
- Equal operands: a = b = 0x1234_5678, op = 110 -> z = 0, ex = 1. Same operands with op = 111 -> z = 0, ex = 1.
- Signed SLT:
  - a = 0x8000_0000, b = 1 -> z = 1.
  - a = 0x7FFF_FFFF, b = 0xFFFF_FFFF -> z = 0.
  - a = -3, b = -2 -> z = 1.
- Random regression: 1000 cycles of random a and b, with b forced equal to a on about 50% of cycles, across all five ops. Compare z and ex against a one-cycle-delayed reference model. Also check that undefined ops give z = 0.

Source files
------------

// File: rtl/y_alu_pkg.sv
// Shared constants for the 32-bit ALU: datapath width and op codes.
package y_alu_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

endpackage

// File: rtl/y_add_sub.sv
// 32-bit ripple-carry adder/subtractor; sub inverts b and sets carry-in.
module y_add_sub
    import y_alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] sum,
    output logic              cout,
    output logic              ovf
);

    logic [DATA_W:0]   carry;
    logic [DATA_W-1:0] bx;

    always_comb begin
        bx       = sub ? ~b : b;
        carry    = '0;
        sum      = '0;
        carry[0] = sub;
        for (int i = 0; i < DATA_W; i++) begin
            sum[i]       = a[i] ^ bx[i] ^ carry[i];
            carry[i + 1] = (a[i] & bx[i]) | (carry[i] & (a[i] ^ bx[i]));
        end
    end

    assign cout = carry[DATA_W];
    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign ovf  = carry[DATA_W] ^ carry[DATA_W-1];

endmodule

// File: rtl/y_alu.sv
// Registered 32-bit ALU: AND/OR/ADD/SUB/SLT with zero flag, one-cycle latency.
module y_alu
    import y_alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    output logic [DATA_W-1:0] z,
    output logic              ex,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op
);

    logic [DATA_W-1:0] sum;
    logic              unused_carry;
    logic              ovf;
    logic              slt;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] z_q;
    logic              ex_q;

    // op[2] selects subtract, so SUB and SLT share the one adder.
    y_add_sub u_add_sub (
        .a    (a),
        .b    (b),
        .sub  (op[2]),
        .sum  (sum),
        .cout (unused_carry),
        .ovf  (ovf)
    );

    assign slt = sum[DATA_W-1] ^ ovf;

    always_comb begin
        result = '0;
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_ADD:  result = sum;
            OP_SUB:  result = sum;
            OP_SLT:  result = {{(DATA_W-1){1'b0}}, slt};
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            z_q  <= '0;
            ex_q <= 1'b1;
        end else begin
            z_q  <= result;
            ex_q <= (result == '0);
        end
    end

    assign z  = z_q;
    assign ex = ex_q;

endmodule

// File: tb/tb_y_alu.sv
// Directed and random bench for y_alu using a queue scoreboard of expected results.
module tb_y_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] z;
    logic        ex;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;

    typedef struct packed {
        logic [31:0] z;
        logic        ex;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    y_alu dut (
        .clk (clk),
        .rst (rst),
        .z   (z),
        .ex  (ex),
        .a   (a),
        .b   (b),
        .op  (op)
    );

    function automatic logic [31:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic [2:0] mop);
        case (mop)
            3'b000:  return ma & mb;
            3'b001:  return ma | mb;
            3'b010:  return ma + mb;
            3'b110:  return ma - mb;
            3'b111:  return ($signed(ma) < $signed(mb)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check_out();
        exp_t  e;
        string t;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed z=%h required an expected entry", z);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (z === e.z) else begin
                errors++;
                $error("FAIL %s z observed=%h expected=%h", t, z, e.z);
            end
            checks++;
            assert (ex === e.ex) else begin
                errors++;
                $error("FAIL %s ex observed=%b expected=%b", t, ex, e.ex);
            end
        end
    endtask

    // Drive one cycle, queue its expected result, then compare just after the edge.
    task automatic step(input logic r, input logic [31:0] sa, input logic [31:0] sb,
                        input logic [2:0] sop, input string tag);
        exp_t e;
        rst = r;
        a   = sa;
        b   = sb;
        op  = sop;
        e.z  = r ? 32'd0 : model(sa, sb, sop);
        e.ex = (e.z == 32'd0);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rop;

        rst = 1'b1;
        a   = '0;
        b   = '0;
        op  = '0;

        step(1'b1, $urandom, $urandom, 3'($urandom), "reset0");
        step(1'b1, $urandom, $urandom, 3'($urandom), "reset1");
        step(1'b0, 32'd5, 32'd3, 3'b010, "first_add");

        step(1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 3'b000, "and");
        step(1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 3'b001, "or");

        step(1'b0, 32'hFFFF_FFFF, 32'd1, 3'b010, "add_wrap");
        step(1'b0, 32'd0, 32'd1, 3'b110, "sub_wrap");

        step(1'b0, 32'h1234_5678, 32'h1234_5678, 3'b110, "sub_equal");
        step(1'b0, 32'h1234_5678, 32'h1234_5678, 3'b111, "slt_equal");

        step(1'b0, 32'h8000_0000, 32'd1, 3'b111, "slt_min");
        step(1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 3'b111, "slt_max");
        step(1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 3'b111, "slt_neg");
        step(1'b0, 32'd1, 32'h8000_0000, 3'b111, "slt_rev");

        step(1'b0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 3'b011, "undef011");
        step(1'b0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 3'b100, "undef100");
        step(1'b0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 3'b101, "undef101");

        // Mid-stream reset discards the in-flight result.
        step(1'b1, 32'h0000_0010, 32'h0000_0020, 3'b010, "mid_reset");
        step(1'b0, 32'h0000_0010, 32'h0000_0020, 3'b010, "after_reset");

        for (int i = 0; i < 1000; i++) begin
            ra  = $urandom;
            rb  = ($urandom_range(0, 1) == 0) ? ra : $urandom;
            rop = 3'($urandom_range(0, 7));
            step(1'b0, ra, rb, rop, "random");
        end

        if (exp_q.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d required=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "bench timeout");
    end

endmodule
